// File: rtl/pong_dynamic.sv
// pong_dynamic: per-frame game logic feeding the pixel renderer.
// Everything advances only on frame_tick, so the ball and paddle positions are
// stable for a whole frame. The start input is the only thing that can change
// state between ticks (IDLE->PLAY, OVER->PLAY).
// Optional build macro PONG_AI_EN: when defined, paddle 2 follows the ball and
// btn_up2/btn_dn2 are ignored. When undefined, paddle 2 is button driven.
// Interface contract: frame_tick is a single-cycle qualifier. There is no
// backpressure; every output is a register that updates on the clk edge where
// frame_tick (or start) is sampled high, and game_state is the FSM state itself.
module pong_dynamic #(
  parameter int size_ball     = 10,
  parameter int width_screen  = 640,
  parameter int height_screen = 480,
  parameter int separator     = 20,
  parameter int width_player  = 20,
  parameter int height_player = 80,
  parameter int ball_speed    = 2,
  parameter int player_speed  = 4,
  parameter int pause_frames  = 60,
  parameter int max_score     = 9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_up1,
  input  logic       btn_dn1,
  input  logic       btn_up2,
  input  logic       btn_dn2,
  output logic [9:0] x_ball,
  output logic [9:0] y_ball,
  output logic [9:0] pos_player1,
  output logic [9:0] pos_player2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  // 11-bit constants for the collision arithmetic, so nothing wraps at 10 bits
  localparam logic [10:0] sb11     = 11'(size_ball);
  localparam logic [10:0] bs11     = 11'(ball_speed);
  localparam logic [10:0] ps11     = 11'(player_speed);
  localparam logic [10:0] hp11     = 11'(height_player);
  localparam logic [10:0] y_max11  = 11'(height_screen - size_ball);
  localparam logic [10:0] pad_max11 = 11'(height_screen - height_player);
  localparam logic [10:0] face_l11 = 11'(separator + width_player);
  localparam logic [10:0] face_r11 = 11'(width_screen - separator - width_player);
  localparam logic [10:0] scr_w11  = 11'(width_screen);

  // 10-bit position constants
  localparam logic [9:0] bs10      = 10'(ball_speed);
  localparam logic [9:0] ps10      = 10'(player_speed);
  localparam logic [9:0] y_max10   = 10'(height_screen - size_ball);
  localparam logic [9:0] pad_max10 = 10'(height_screen - height_player);
  localparam logic [9:0] pad_init  = 10'((height_screen - height_player) / 2);
  localparam logic [9:0] x_centre  = 10'((width_screen - size_ball) / 2);
  localparam logic [9:0] y_centre  = 10'((height_screen - size_ball) / 2);
  localparam logic [9:0] x_hit_l   = 10'(separator + width_player);
  localparam logic [9:0] x_hit_r   = 10'(width_screen - separator - width_player - size_ball);
  localparam logic [3:0] score_max = 4'(max_score);
  localparam logic [7:0] pause_cnt = 8'(pause_frames);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [9:0] p1_q, p1_d, p2_q, p2_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic       dx_q, dx_d;   // 1 = moving right
  logic       dy_q, dy_d;   // 1 = moving down
  logic [7:0] cnt_q, cnt_d;

  logic [10:0] x11, y11, p1_11, p2_11;
  logic        ov1, ov2, hit_l, hit_r, miss_l, miss_r, wall_top, wall_bot;
  logic        up2_eff, dn2_eff;

  // One paddle step: up/down alone moves with saturation, both or none holds
  function automatic logic [9:0] pad_step(input logic [9:0] pos, input logic up,
                                          input logic dn);
    logic [9:0] r;
    r = pos;
    if (up && !dn) begin
      r = ({1'b0, pos} < ps11) ? 10'd0 : pos - ps10;
    end else if (dn && !up) begin
      r = ({1'b0, pos} + ps11 > pad_max11) ? pad_max10 : pos + ps10;
    end
    return r;
  endfunction

  assign x11   = {1'b0, x_q};
  assign y11   = {1'b0, y_q};
  assign p1_11 = {1'b0, p1_q};
  assign p2_11 = {1'b0, p2_q};

  // Vertical overlap between ball and each paddle, using the current positions
  assign ov1 = (y11 + sb11 > p1_11) && (y11 < p1_11 + hp11);
  assign ov2 = (y11 + sb11 > p2_11) && (y11 < p2_11 + hp11);

  assign wall_top = !dy_q && (y11 < bs11);
  assign wall_bot = dy_q && (y11 + bs11 > y_max11);
  assign hit_l    = !dx_q && (x11 >= face_l11) && (x11 - bs11 < face_l11) && ov1;
  assign hit_r    = dx_q && (x11 + sb11 <= face_r11) && (x11 + sb11 + bs11 > face_r11) && ov2;
  assign miss_l   = !dx_q && (x11 < bs11);
  assign miss_r   = (x11 + sb11 + bs11 > scr_w11);

`ifdef PONG_AI_EN
  // Paddle 2 steers its centre toward the ball centre
  assign up2_eff = (y11 + 11'(size_ball / 2)) < (p2_11 + 11'(height_player / 2));
  assign dn2_eff = (y11 + 11'(size_ball / 2)) > (p2_11 + 11'(height_player / 2));
`else
  assign up2_eff = btn_up2;
  assign dn2_eff = btn_dn2;
`endif

  // State register: all game state, cleared asynchronously by clr
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      x_q     <= x_centre;
      y_q     <= y_centre;
      p1_q    <= pad_init;
      p2_q    <= pad_init;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: paddles, ball motion, scoring and serve/pause/game-over sequencing
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cnt_d   = cnt_q;

    if (frame_tick && (state_q != ST_OVER)) begin
      p1_d = pad_step(p1_q, btn_up1, btn_dn1);
      p2_d = pad_step(p2_q, up2_eff, dn2_eff);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (wall_top) begin
            y_d  = 10'd0;
            dy_d = 1'b1;
          end else if (wall_bot) begin
            y_d  = y_max10;
            dy_d = 1'b0;
          end else begin
            y_d = dy_q ? (y_q + bs10) : (y_q - bs10);
          end

          if (hit_l) begin
            x_d  = x_hit_l;
            dx_d = 1'b1;
          end else if (hit_r) begin
            x_d  = x_hit_r;
            dx_d = 1'b0;
          end else if (miss_l || miss_r) begin
            if (miss_l) begin
              s2_d = (s2_q < score_max) ? s2_q + 4'd1 : s2_q;
            end else begin
              s1_d = (s1_q < score_max) ? s1_q + 4'd1 : s1_q;
            end
            x_d     = x_centre;
            y_d     = y_centre;
            dx_d    = ~dx_q;
            cnt_d   = pause_cnt;
            state_d = ST_SCORED;
          end else begin
            x_d = dx_q ? (x_q + bs10) : (x_q - bs10);
          end
        end
      end
      ST_SCORED: begin
        // The tick that exhausts the pause also leaves SCORED, so the ball
        // sits at centre for exactly pause_frames ticks
        if (frame_tick) begin
          if (cnt_q < 8'd2) begin
            cnt_d   = 8'd0;
            state_d = ((s1_q == score_max) || (s2_q == score_max)) ? ST_OVER : ST_PLAY;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (start) begin
          s1_d    = 4'd0;
          s2_d    = 4'd0;
          x_d     = x_centre;
          y_d     = y_centre;
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign x_ball      = x_q;
  assign y_ball      = y_q;
  assign pos_player1 = p1_q;
  assign pos_player2 = p2_q;
  assign score1      = s1_q;
  assign score2      = s2_q;
  assign game_state  = state_q;

endmodule

// File: tb/tb_pong_dynamic.sv
// Bench for pong_dynamic: a rule-level game model compared every cycle, plus
// hand-computed checkpoints along a scripted game that reaches game over.
module tb_pong_dynamic;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       btn_up1 = 1'b0, btn_dn1 = 1'b0, btn_up2 = 1'b0, btn_dn2 = 1'b0;
  logic [9:0] x_ball, y_ball, pos_player1, pos_player2;
  logic [3:0] score1, score2;
  logic [1:0] game_state;

  int n_vec = 0;
  int n_bad = 0;

  // paddle auto-steering toward targets (used during play)
  bit auto_pad = 1'b0;
  int tgt1 = 200;
  int tgt2 = 200;

  pong_dynamic dut (
    .clk(clk), .clr(clr), .frame_tick(frame_tick), .start(start),
    .btn_up1(btn_up1), .btn_dn1(btn_dn1), .btn_up2(btn_up2), .btn_dn2(btn_dn2),
    .x_ball(x_ball), .y_ball(y_ball), .pos_player1(pos_player1),
    .pos_player2(pos_player2), .score1(score1), .score2(score2),
    .game_state(game_state)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- game model (states: 0 idle, 1 play, 2 scored, 3 over)
  int m_x = 315, m_y = 235, m_p1 = 200, m_p2 = 200;
  int m_s1 = 0, m_s2 = 0, m_st = 0, m_cnt = 0;
  bit m_right = 1'b1, m_down = 1'b1;

  function automatic int move_pad(input int p, input bit up, input bit dn);
    if (up && !dn) return (p >= 4) ? p - 4 : 0;
    if (dn && !up) return (p + 4 <= 400) ? p + 4 : 400;
    return p;
  endfunction

  always @(posedge clk or posedge clr) begin : model_proc
    int op1, op2, nx, ny;
    bit ov1, ov2, left_miss;
    if (clr) begin
      m_x = 315; m_y = 235; m_p1 = 200; m_p2 = 200;
      m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0;
      m_right = 1'b1; m_down = 1'b1;
    end else begin
      op1 = m_p1;
      op2 = m_p2;
      if (frame_tick && m_st != 3) begin
        m_p1 = move_pad(op1, btn_up1, btn_dn1);
        m_p2 = move_pad(op2, btn_up2, btn_dn2);
      end
      if (m_st == 0) begin
        if (start) m_st = 1;
      end else if (m_st == 1) begin
        if (frame_tick) begin
          if (!m_down && m_y < 2) begin ny = 0; m_down = 1'b1; end
          else if (m_down && m_y + 2 > 470) begin ny = 470; m_down = 1'b0; end
          else ny = m_down ? m_y + 2 : m_y - 2;
          ov1 = (m_y + 10 > op1) && (m_y < op1 + 80);
          ov2 = (m_y + 10 > op2) && (m_y < op2 + 80);
          left_miss = !m_right && m_x < 2;
          if (!m_right && m_x >= 40 && m_x - 2 < 40 && ov1) begin
            nx = 40; m_right = 1'b1;
          end else if (m_right && m_x + 10 <= 600 && m_x + 12 > 600 && ov2) begin
            nx = 590; m_right = 1'b0;
          end else if (left_miss || m_x + 12 > 640) begin
            if (left_miss) m_s2 = (m_s2 < 9) ? m_s2 + 1 : 9;
            else m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9;
            nx = 315; ny = 235; m_right = !m_right; m_cnt = 60; m_st = 2;
          end else begin
            nx = m_right ? m_x + 2 : m_x - 2;
          end
          m_x = nx;
          m_y = ny;
        end
      end else if (m_st == 2) begin
        if (frame_tick) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) m_st = (m_s1 == 9 || m_s2 == 9) ? 3 : 1;
        end
      end else begin
        if (start) begin
          m_s1 = 0; m_s2 = 0; m_x = 315; m_y = 235; m_st = 1;
        end
      end
    end
  end

  // ---------------- scoreboard
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // compare process: DUT against the model on every falling edge
  always @(negedge clk) begin
    chk("model x_ball", int'(x_ball), m_x);
    chk("model y_ball", int'(y_ball), m_y);
    chk("model pos_player1", int'(pos_player1), m_p1);
    chk("model pos_player2", int'(pos_player2), m_p2);
    chk("model score1", int'(score1), m_s1);
    chk("model score2", int'(score2), m_s2);
    chk("model game_state", int'(game_state), m_st);
  end

  // ---------------- driver tasks (called at a falling edge, return at one)
  task automatic cyc(input bit t, input bit s);
    frame_tick = t;
    start = s;
    @(negedge clk);
    frame_tick = 1'b0;
    start = 1'b0;
  endtask

  task automatic frame(input bit s);
    if (auto_pad) begin
      btn_up1 = (m_p1 > tgt1); btn_dn1 = (m_p1 < tgt1);
      btn_up2 = (m_p2 > tgt2); btn_dn2 = (m_p2 < tgt2);
    end
    cyc(1'b1, s);
    if (auto_pad) begin
      btn_up1 = 1'b0; btn_dn1 = 1'b0; btn_up2 = 1'b0; btn_dn2 = 1'b0;
    end
    repeat (3) cyc(1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0);
  endtask

  task automatic wait_state(input int st, input int budget, input string nm);
    int k;
    k = 0;
    while (int'(game_state) != st && k < budget) begin
      frame(1'b0);
      k++;
    end
    chk(nm, int'(game_state), st);
  endtask

  task automatic chk_ball(input string nm, input int ex, input int ey);
    chk({nm, " x"}, int'(x_ball), ex);
    chk({nm, " y"}, int'(y_ball), ey);
  endtask

  // ---------------- directed scenario
  initial begin
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // reset values
    chk_ball("reset", 315, 235);
    chk("reset pad1", int'(pos_player1), 200);
    chk("reset pad2", int'(pos_player2), 200);
    chk("reset score1", int'(score1), 0);
    chk("reset score2", int'(score2), 0);
    chk("reset state", int'(game_state), 0);

    // idle ticks leave the ball alone
    frames(3);
    chk_ball("idle hold", 315, 235);

    // paddles: both pressed holds, single buttons saturate at 0 and 400
    btn_up1 = 1; btn_dn1 = 1; btn_up2 = 1; btn_dn2 = 1;
    frames(5);
    chk("both held pad1", int'(pos_player1), 200);
    chk("both held pad2", int'(pos_player2), 200);
    btn_dn1 = 0; btn_up2 = 0;
    frames(60);
    chk("up1 sat pad1", int'(pos_player1), 0);
    chk("dn2 sat pad2", int'(pos_player2), 400);
    btn_up1 = 0; btn_dn1 = 1; btn_up2 = 1; btn_dn2 = 0;
    frames(50);
    chk("dn1 pad1", int'(pos_player1), 200);
    chk("up2 pad2", int'(pos_player2), 200);
    btn_up2 = 0;
    frames(50);
    chk("dn1 pad1 to 400", int'(pos_player1), 400);
    btn_dn1 = 0;

    // start coincident with a tick: state changes, ball stays
    auto_pad = 1; tgt1 = 400; tgt2 = 200;
    frame(1'b1);
    chk("start state", int'(game_state), 1);
    chk_ball("start no move", 315, 235);

    // first serve goes right and beats paddle 2
    wait_state(2, 400, "serve1 scored");
    chk("serve1 score1", int'(score1), 1);
    chk("serve1 score2", int'(score2), 0);
    chk_ball("serve1 recentre", 315, 235);
    frames(59);
    chk("pause still scored", int'(game_state), 2);
    frames(1);
    chk("pause over", int'(game_state), 1);

    // second serve: up and left, bounces off the top wall
    frames(117);
    chk_ball("before top wall", 81, 1);
    frames(1);
    chk_ball("top wall", 79, 0);
    frames(1);
    chk_ball("after top wall", 77, 2);

    // paddle 1 parked at 400 misses: point to player 2
    wait_state(2, 400, "serve2 scored");
    chk("serve2 score2", int'(score2), 1);
    chk("serve2 score1", int'(score1), 1);
    chk_ball("serve2 recentre", 315, 235);

    // paddle 1 moves up to 0 for the later rallies
    tgt1 = 0;
    frames(60);
    wait_state(2, 400, "serve3 scored");
    chk("serve3 score1", int'(score1), 2);
    frames(60);
    chk("serve4 play", int'(game_state), 1);
    chk("pad1 at top", int'(pos_player1), 0);

    // left paddle return
    frames(137);
    chk_ball("before left hit", 41, 38);
    frames(1);
    chk_ball("left hit", 40, 40);
    frames(1);
    chk_ball("after left hit", 42, 42);

    // rallies until player 1 reaches the winning score
    wait_state(3, 5000, "game over");
    chk("over score1", int'(score1), 9);
    chk("over score2", int'(score2), 1);
    chk_ball("over ball", 315, 235);

    // game over freezes paddles
    auto_pad = 0;
    btn_dn1 = 1; btn_dn2 = 1;
    frames(5);
    chk("over pad1 frozen", int'(pos_player1), 0);
    chk("over pad2 frozen", int'(pos_player2), 200);
    chk("over state held", int'(game_state), 3);
    btn_dn1 = 0; btn_dn2 = 0;

    // restart between ticks
    cyc(1'b0, 1'b1);
    chk("restart state", int'(game_state), 1);
    chk("restart score1", int'(score1), 0);
    chk("restart score2", int'(score2), 0);
    chk_ball("restart ball", 315, 235);
    frames(10);
    chk_ball("restart play", 295, 215);

    // asynchronous clear in the middle of a clock period
    #2 clr = 1'b1;
    #1;
    chk_ball("async clr", 315, 235);
    chk("async clr pad1", int'(pos_player1), 200);
    chk("async clr state", int'(game_state), 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
